// File: rtl/iniciador_memoria_if.sv
// Bus between the multicycle control unit / memory and the memory-access sequencer.
// master: the sequencer; slave: control unit plus memory side.
interface iniciador_memoria_if;
  logic        reqFetch;
  logic        reqLoad;
  logic        reqStore;
  logic [5:0]  pc;
  logic [5:0]  aluAddr;
  logic [15:0] storeData;
  logic [15:0] dataIR;
  logic [15:0] dataMDR;
  logic [5:0]  addrMem;
  logic        readMem;
  logic        writeMem;
  logic [15:0] data;
  logic [3:0]  state;
  logic [15:0] ir;
  logic [15:0] mdr;
  logic        busy;
  logic        done;
  logic        badAddr;

  modport master (
    input  reqFetch, reqLoad, reqStore, pc, aluAddr, storeData, dataIR, dataMDR,
    output addrMem, readMem, writeMem, data, state, ir, mdr, busy, done, badAddr
  );

  modport slave (
    output reqFetch, reqLoad, reqStore, pc, aluAddr, storeData, dataIR, dataMDR,
    input  addrMem, readMem, writeMem, data, state, ir, mdr, busy, done, badAddr
  );
endinterface

// File: rtl/iniciador_memoria.sv
// Memory-access sequencer: fetch/load/store requests become glitch-free registered
// strobes toward the 50-word memory; read results land in ir or mdr.
module iniciador_memoria #(
  parameter int         MEM_WORDS = 50,
  parameter logic [3:0] ST_WRITE  = 4'b1011,
  parameter logic [3:0] ST_NONE   = 4'b0000
) (
  input logic clock,
  input logic reset,
  iniciador_memoria_if.master bus
);

  typedef enum logic [2:0] {
    IDLE, RD_SETUP, RD_STROBE, WR_SETUP, WR_ARM, WR_FALL, FINISH
  } fsm_t;

  typedef enum logic [1:0] {OP_FETCH, OP_LOAD, OP_STORE} op_t;

  fsm_t       fsm;
  op_t        op;
  logic       pend;
  logic       bad;
  logic [5:0] sel_addr;
  logic       addr_bad;

  always_comb begin
    sel_addr = bus.aluAddr;
    if (!bus.reqStore && !bus.reqLoad) sel_addr = bus.pc;
  end

  assign addr_bad = ({1'b0, sel_addr} >= 7'(MEM_WORDS));

  // Accept in IDLE takes one extra cycle (pend) so every strobe starts one edge
  // after the request edge, with address and data already stable.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      fsm          <= IDLE;
      op           <= OP_FETCH;
      pend         <= 1'b0;
      bad          <= 1'b0;
      bus.addrMem  <= '0;
      bus.readMem  <= 1'b0;
      bus.writeMem <= 1'b0;
      bus.data     <= '0;
      bus.state    <= ST_NONE;
      bus.ir       <= '0;
      bus.mdr      <= '0;
      bus.busy     <= 1'b0;
      bus.done     <= 1'b0;
      bus.badAddr  <= 1'b0;
    end else begin
      case (fsm)
        IDLE: begin
          if (pend) begin
            pend <= 1'b0;
            if (bad) begin
              fsm         <= FINISH;
              bus.done    <= 1'b1;
              bus.badAddr <= 1'b1;
            end else if (op == OP_STORE) begin
              fsm          <= WR_SETUP;
              bus.writeMem <= 1'b1;
            end else begin
              fsm <= RD_SETUP;
            end
          end else if (bus.reqStore || bus.reqLoad || bus.reqFetch) begin
            pend        <= 1'b1;
            bus.busy    <= 1'b1;
            bus.addrMem <= sel_addr;
            bad         <= addr_bad;
            if (bus.reqStore) begin
              op       <= OP_STORE;
              bus.data <= bus.storeData;
            end else if (bus.reqLoad) begin
              op <= OP_LOAD;
            end else begin
              op <= OP_FETCH;
            end
          end
        end
        RD_SETUP: begin
          fsm         <= RD_STROBE;
          bus.readMem <= 1'b1;
        end
        RD_STROBE: begin
          fsm         <= FINISH;
          bus.readMem <= 1'b0;
          bus.done    <= 1'b1;
          if (op == OP_FETCH) bus.ir <= bus.dataIR;
          else                bus.mdr <= bus.dataMDR;
        end
        WR_SETUP: begin
          fsm       <= WR_ARM;
          bus.state <= ST_WRITE;
        end
        WR_ARM: begin
          fsm          <= WR_FALL;
          bus.writeMem <= 1'b0;
        end
        WR_FALL: begin
          fsm       <= FINISH;
          bus.state <= ST_NONE;
          bus.done  <= 1'b1;
        end
        FINISH: begin
          fsm         <= IDLE;
          bus.done    <= 1'b0;
          bus.badAddr <= 1'b0;
          bus.busy    <= 1'b0;
        end
        default: fsm <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_iniciador_memoria.sv
// Directed bench for iniciador_memoria: vector table of single accesses plus
// hand-written reset, arbitration and held-request sequences against a memory model.
module tb_iniciador_memoria;
  logic clock = 1'b0;
  logic reset = 1'b1;

  iniciador_memoria_if bus ();

  iniciador_memoria dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  logic [15:0] mem [0:49];
  int rd_pulses = 0;
  int wr_falls  = 0;
  int wr_bad    = 0;
  int st_bad    = 0;
  int stab_err  = 0;
  int n_cmp     = 0;
  int n_err     = 0;

  // Memory model: read sampled on readMem rise, write on writeMem fall in ST_WRITE.
  always @(posedge bus.readMem) begin
    if (!reset) begin
      rd_pulses++;
      if (bus.addrMem < 6'd50) begin
        bus.dataIR  <= mem[bus.addrMem];
        bus.dataMDR <= mem[bus.addrMem];
      end
    end
  end

  always @(negedge bus.writeMem) begin
    if (!reset) begin
      if (bus.state == 4'b1011) begin
        wr_falls++;
        if (bus.addrMem < 6'd50) mem[bus.addrMem] = bus.data;
      end else begin
        wr_bad++;
      end
    end
  end

  always @(bus.state) if (bus.state == 4'b1010) st_bad++;

  always @(bus.addrMem or bus.data)
    if (!reset && (bus.readMem || bus.writeMem || bus.state == 4'b1011)) stab_err++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic run_req(input logic f, input logic l, input logic s,
                         input logic [5:0] p, input logic [5:0] a, input logic [15:0] sd,
                         output int lat, output logic bad_seen);
    @(negedge clock);
    bus.reqFetch = f; bus.reqLoad = l; bus.reqStore = s;
    bus.pc = p; bus.aluAddr = a; bus.storeData = sd;
    rd_pulses = 0; wr_falls = 0;
    @(posedge clock);
    #1;
    bus.reqFetch = 1'b0; bus.reqLoad = 1'b0; bus.reqStore = 1'b0;
    lat = 0; bad_seen = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      @(posedge clock);
      #1;
      if (bus.done) begin
        lat = c;
        bad_seen = bus.badAddr;
        break;
      end
    end
    @(posedge clock);
  endtask

  typedef struct {
    int          op;       // 0 fetch, 1 load, 2 store
    logic [5:0]  addr;
    logic [15:0] wdata;
    logic [15:0] exp_val;
    int          exp_lat;
    logic        exp_bad;
    int          exp_rd;
    int          exp_wr;
  } vec_t;

  vec_t vecs [10];

  initial begin
    int lat;
    logic bad_seen;
    int first_done, second_done, done_cnt;

    for (int i = 0; i < 50; i++) mem[i] = 16'h1000 + 16'(i);
    mem[0]  = 16'h2010;
    mem[45] = 16'hC000;
    mem[49] = 16'hBEEF;

    vecs[0] = '{0, 6'd0,  16'h0000, 16'h2010, 3, 1'b0, 1, 0};
    vecs[1] = '{0, 6'd45, 16'h0000, 16'hC000, 3, 1'b0, 1, 0};
    vecs[2] = '{2, 6'd46, 16'hA5A5, 16'hA5A5, 4, 1'b0, 0, 1};
    vecs[3] = '{1, 6'd46, 16'h0000, 16'hA5A5, 3, 1'b0, 1, 0};
    vecs[4] = '{1, 6'd50, 16'h0000, 16'hA5A5, 1, 1'b1, 0, 0};
    vecs[5] = '{1, 6'd63, 16'h0000, 16'hA5A5, 1, 1'b1, 0, 0};
    vecs[6] = '{0, 6'd49, 16'h0000, 16'hBEEF, 3, 1'b0, 1, 0};
    vecs[7] = '{0, 6'd50, 16'h0000, 16'hBEEF, 1, 1'b1, 0, 0};
    vecs[8] = '{2, 6'd63, 16'h1111, 16'h0000, 1, 1'b1, 0, 0};
    vecs[9] = '{1, 6'd0,  16'h0000, 16'h2010, 3, 1'b0, 1, 0};

    bus.reqFetch = 1'b0; bus.reqLoad = 1'b0; bus.reqStore = 1'b0;
    bus.pc = '0; bus.aluAddr = '0; bus.storeData = '0;
    bus.dataIR = '0; bus.dataMDR = '0;

    repeat (2) @(posedge clock);
    @(negedge clock) reset = 1'b0;
    repeat (2) @(posedge clock);

    // Reset asserted while idle
    @(negedge clock) reset = 1'b1;
    #2;
    @(negedge clock) reset = 1'b0;
    #1;
    check("rst_strobes", {27'd0, bus.readMem, bus.writeMem, bus.busy, bus.done, bus.badAddr}, 32'd0);
    check("rst_state",   {28'd0, bus.state}, 32'd0);
    check("rst_addr",    {26'd0, bus.addrMem}, 32'd0);
    check("rst_data",    {16'd0, bus.data}, 32'd0);
    check("rst_ir_mdr",  {bus.ir, bus.mdr}, 32'd0);

    // Reset in RD_STROBE: readMem drops at once, ir keeps its pre-fetch value
    @(negedge clock);
    bus.reqFetch = 1'b1; bus.pc = 6'd0;
    @(posedge clock);
    #1 bus.reqFetch = 1'b0;
    @(posedge clock);
    @(posedge clock);
    #2;
    check("mid_rd_strobe_hi", {31'd0, bus.readMem}, 32'd1);
    reset = 1'b1;
    #1;
    check("mid_rd_strobe_lo", {31'd0, bus.readMem}, 32'd0);
    check("mid_rd_busy",      {31'd0, bus.busy}, 32'd0);
    check("mid_rd_ir",        {16'd0, bus.ir}, 32'd0);
    @(negedge clock) reset = 1'b0;
    done_cnt = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clock);
      if (bus.done) done_cnt++;
    end
    check("mid_rd_no_done", done_cnt, 0);
    check("mid_rd_ir_after", {16'd0, bus.ir}, 32'd0);

    for (int i = 0; i < 10; i++) begin
      run_req(vecs[i].op == 0, vecs[i].op == 1, vecs[i].op == 2,
              vecs[i].addr, vecs[i].addr, vecs[i].wdata, lat, bad_seen);
      check($sformatf("v%0d_latency", i), lat, vecs[i].exp_lat);
      check($sformatf("v%0d_badAddr", i), {31'd0, bad_seen}, {31'd0, vecs[i].exp_bad});
      check($sformatf("v%0d_rd_pulses", i), rd_pulses, vecs[i].exp_rd);
      check($sformatf("v%0d_wr_falls", i), wr_falls, vecs[i].exp_wr);
      if (vecs[i].op == 0)
        check($sformatf("v%0d_ir", i), {16'd0, bus.ir}, {16'd0, vecs[i].exp_val});
      else if (vecs[i].op == 1)
        check($sformatf("v%0d_mdr", i), {16'd0, bus.mdr}, {16'd0, vecs[i].exp_val});
      else if (!vecs[i].exp_bad)
        check($sformatf("v%0d_mem", i), {16'd0, mem[vecs[i].addr]}, {16'd0, vecs[i].exp_val});
    end

    // Store and fetch together: store wins, ir untouched
    run_req(1'b1, 1'b0, 1'b1, 6'd0, 6'd47, 16'h5A5A, lat, bad_seen);
    check("arb_latency", lat, 4);
    check("arb_ir",      {16'd0, bus.ir}, 32'h0000BEEF);
    check("arb_mem",     {16'd0, mem[47]}, 32'h00005A5A);
    check("arb_rd",      rd_pulses, 0);

    // Load held through a store: load accepted on first IDLE edge after FINISH
    @(negedge clock);
    bus.reqStore = 1'b1; bus.reqLoad = 1'b1;
    bus.aluAddr = 6'd48; bus.storeData = 16'h0F0F;
    @(posedge clock);
    #1 bus.reqStore = 1'b0;
    first_done = 0; second_done = 0;
    for (int k = 1; k <= 12; k++) begin
      @(posedge clock);
      #1;
      if (bus.done) begin
        if (first_done == 0) first_done = k;
        else if (second_done == 0) begin
          second_done = k;
          bus.reqLoad = 1'b0;
        end
      end
    end
    bus.reqLoad = 1'b0;
    check("held_store_done", first_done, 4);
    check("held_load_done",  second_done, 9);
    check("held_load_mdr",   {16'd0, bus.mdr}, 32'h00000F0F);

    check("state_1010_seen", st_bad, 0);
    check("addr_data_stable", stab_err, 0);
    check("wr_fall_outside_st_write", wr_bad, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no end of test expected finish");
    $fatal(1);
  end
endmodule

// File: doc/iniciador_memoria.md
# iniciador_memoria

Memory-access sequencer on the processor side of the 50-word, 16-bit instruction/data memory. It accepts fetch, load and store requests from the multicycle control unit. It drives the memory's edge-sensitive `readMem`/`writeMem` strobes, address, write data and state code with glitch-free registered timing. Read results are captured into the instruction register (`ir`) or the memory data register (`mdr`), and `done` is pulsed when the access completes.

## Interface
- `MEM_WORDS`, 50: number of valid memory words; addresses ≥ MEM_WORDS are rejected.
- `ST_WRITE`, 4'b1011: state code the memory requires for a write to commit.
- `ST_NONE`, 4'b0000: state code driven whenever no write is in progress (never 4'b1010).
- `clock`  in  1  single system clock, rising-edge active.
- `reset`  in  1  asynchronous, active-high reset.
- `reqFetch`  in  1  request an instruction read at `pc`; sampled only in IDLE.
- `reqLoad`  in  1  request a data read at `aluAddr`; sampled only in IDLE.
- `reqStore`  in  1  request a write of `storeData` to `aluAddr`; sampled only in IDLE.
- `pc`  in  6  fetch address.
- `aluAddr`  in  6  load/store address.
- `storeData`  in  16  store data.
- `dataIR`  in  16  memory read port (instruction path).
- `dataMDR`  in  16  memory read port (data path).
- `addrMem`  out  6  memory address.
- `readMem`  out  1  read strobe; the memory samples on its rising edge.
- `writeMem`  out  1  write strobe; the memory writes on its falling edge while `state`==ST_WRITE.
- `data`  out  16  write data to memory.
- `state`  out  4  state code to memory.
- `ir`  out  16  instruction register.
- `mdr`  out  16  memory data register.
- `busy`  out  1  high in every non-IDLE state.
- `done`  out  1  one-cycle completion pulse.
- `badAddr`  out  1  one-cycle pulse coincident with `done` for a rejected address.

## Operation
- All outputs are registered. No strobe is decoded combinationally.
- States: IDLE, RD_SETUP, RD_STROBE, WR_SETUP, WR_ARM, WR_FALL, FINISH.
- Request selection in IDLE, priority store > load > fetch:
  - Lower-priority requests in the same cycle are dropped, not queued.
  - Requests while `busy`=1 are ignored.
- Address latch: the selected address (`pc` for fetch, `aluAddr` otherwise) is latched into `addrMem` on accept and held until FINISH. For a store, `storeData` is latched into `data` on accept.
- Range check on accept: address ≥ MEM_WORDS goes directly to FINISH with `badAddr`=1. No strobe toggles, and `ir`/`mdr` are unchanged.
- Read path:
  - RD_SETUP: `readMem`=0, address stable.
  - RD_STROBE: `readMem`=1.
  - On the edge leaving RD_STROBE, `ir`←`dataIR` (fetch) or `mdr`←`dataMDR` (load).
  - FINISH: `readMem`=0.
- Write path:
  - WR_SETUP: `writeMem`=1, `state`=ST_NONE.
  - WR_ARM: `writeMem`=1, `state`=ST_WRITE.
  - WR_FALL: `writeMem`=0, `state`=ST_WRITE; the commit edge happens here.
  - FINISH: `state`=ST_NONE.
- FINISH: `done`=1, then return to IDLE. A new request may be accepted in the cycle after FINISH.
- Reset (asynchronous):
  - All outputs go to 0 and the FSM goes to IDLE, including mid-operation.
  - Reset in RD_SETUP, RD_STROBE, or WR_SETUP leaves the memory contents unchanged; in WR_SETUP, `writeMem` falls with `state`=ST_NONE, so no write occurs.
  - Reset in WR_ARM or WR_FALL: commit is undefined; benches must not check that location.

## Timing
- Request sampled at edge E0.
- Read: `readMem` rises at E2. `ir`/`mdr` are valid and `done` is high from E3 to E4. Latency 3 cycles, with exactly one `readMem` pulse of one cycle.
- Write: `writeMem` rises at E1 and `state`=ST_WRITE from E2 to E4. `writeMem` falls at E3, strictly inside the ST_WRITE window. `done` is high from E4 to E5. Latency 4 cycles.
- Rejected address: `done`/`badAddr` high from E1 to E2.
- `addrMem` and `data` never change while a strobe is high or `state`=ST_WRITE.

## Test plan
- Reset: assert `reset` mid-idle, then release → every output is 0 and `busy`=0. `state` never shows 4'b1010.
- Fetch: `reqFetch`, `pc`=0 → one `readMem` pulse at E2, `ir`=16'h2010 with `done` at E3. Then `pc`=45 → `ir`=16'hC000.
- Store then load: store 16'hA5A5 to 46, then load 46 → exactly one `writeMem` fall, occurring while `state`=4'b1011, with `done` at E4. Then `mdr`=16'hA5A5 with `done` at E3.
- Rejected address: load at `aluAddr`=50 (and 63) → `done`+`badAddr` at E1, no strobe edges, `mdr` unchanged.
- Arbitration:
  - `reqStore`+`reqFetch` together → only the store executes and `ir` is unchanged.
  - `reqLoad` held through a busy store → the load starts on the first IDLE cycle after FINISH.
- Reset mid-read: assert `reset` in RD_STROBE → `readMem` drops immediately, `ir` keeps its prior value, and the FSM is in IDLE with `done` never pulsed.
